// File: rtl/elevator_call_latch_if.sv
// Bundles the call-latch front end: raw button inputs, car status from the controller,
// and the latched call vectors returned to the controller.
interface elevator_call_latch_if #(
    parameter int N = 8
);
    logic [N-1:0] raw_up;
    logic [N-1:0] raw_down;
    logic [N-1:0] raw_cab;
    logic [N-1:0] floor_sensor;
    logic         open_door;
    logic         direction_up;
    logic         direction_down;
    logic         fire_alert;
    logic [N-1:0] button_up;
    logic [N-1:0] button_down;
    logic [N-1:0] button_select_floor;
    logic         call_pending;

    modport master (
        output raw_up, raw_down, raw_cab, floor_sensor,
        output open_door, direction_up, direction_down, fire_alert,
        input  button_up, button_down, button_select_floor, call_pending
    );

    modport slave (
        input  raw_up, raw_down, raw_cab, floor_sensor,
        input  open_door, direction_up, direction_down, fire_alert,
        output button_up, button_down, button_select_floor, call_pending
    );
endinterface

// File: rtl/elevator_call_latch.sv
// Synchronises, debounces and latches hall/cab calls; clears them as the car serves floors.
// Optional macro CALL_CANCEL_EN: a second accepted cab press on a latched floor cancels it.
module elevator_call_latch #(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    elevator_call_latch_if.slave bus
);
    localparam int NB = 3 * N;
    localparam logic [N-1:0] UP_MASK   = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] DOWN_MASK = {{(N-1){1'b1}}, 1'b0};

    logic [NB-1:0] raw_all;
    logic [NB-1:0] accept;
    logic [1:0]    sync_ok_reg;

    logic [N-1:0] up_reg, down_reg, cab_reg;
    logic [N-1:0] up_next, down_next, cab_next;
    logic         pending_reg;

    assign raw_all = {bus.raw_cab, bus.raw_down, bus.raw_up};

    // Marks when q2 carries real samples again after reset, so a button held through
    // reset is not mistaken for a release.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ok_reg <= 2'b00;
        end else begin
            sync_ok_reg <= {sync_ok_reg[0], 1'b1};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : bit_g
            logic             q1_reg, q2_reg, arm_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    q1_reg  <= 1'b0;
                    q2_reg  <= 1'b0;
                    arm_reg <= 1'b0;
                    cnt_reg <= '0;
                end else begin
                    q1_reg <= raw_all[gi];
                    q2_reg <= q1_reg;
                    if (!q2_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg < CNT_W'(DEBOUNCE_CYCLES)) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                    if (sync_ok_reg[1] && !q2_reg) begin
                        arm_reg <= 1'b1;
                    end
                end
            end

            // One pulse per press: the edge where the counter reaches its saturation value.
            assign accept[gi] = arm_reg && q2_reg && (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));
        end
    endgenerate

    always_comb begin
        logic [N-1:0] svc;
        logic [N-1:0] clr_up, clr_down;
        logic         onehot;
        logic         idle_dir;
        logic [N-1:0] acc_up, acc_down, acc_cab;

        onehot   = (bus.floor_sensor != '0) &&
                   ((bus.floor_sensor & (bus.floor_sensor - N'(1))) == '0);
        svc      = (bus.open_door && onehot) ? bus.floor_sensor : '0;
        idle_dir = !bus.direction_up && !bus.direction_down;
        clr_up   = (bus.direction_up   || idle_dir) ? svc : '0;
        clr_down = (bus.direction_down || idle_dir) ? svc : '0;

        acc_up   = accept[N-1:0]    & UP_MASK;
        acc_down = accept[2*N-1:N]  & DOWN_MASK;
        acc_cab  = accept[NB-1:2*N];

        up_next   = (up_reg   | acc_up)   & ~clr_up;
        down_next = (down_reg | acc_down) & ~clr_down;
`ifdef CALL_CANCEL_EN
        cab_next  = (cab_reg ^ acc_cab) & ~svc;
`else
        cab_next  = (cab_reg | acc_cab) & ~svc;
`endif
        if (bus.fire_alert) begin
            up_next   = '0;
            down_next = '0;
            cab_next  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_reg      <= '0;
            down_reg    <= '0;
            cab_reg     <= '0;
            pending_reg <= 1'b0;
        end else begin
            up_reg      <= up_next;
            down_reg    <= down_next;
            cab_reg     <= cab_next;
            // Fire mode drops the pending flag together with the latches.
            pending_reg <= bus.fire_alert ? 1'b0 : |{up_reg, down_reg, cab_reg};
        end
    end

    assign bus.button_up           = up_reg;
    assign bus.button_down         = down_reg;
    assign bus.button_select_floor = cab_reg;
    assign bus.call_pending        = pending_reg;
endmodule
